// File: rtl/pixel_sink_pkg.sv
// pixel_sink_pkg
// Shared constants and the FIFO entry layout for the pixel sink FIFO.
// Contents:
//   PIX_W           - pixel width in bits
//   entry_t/ENTRY_W - stored entry {eof, eol, pixel}
//   DEF_*           - default image geometry and FIFO depth
package pixel_sink_pkg;

    localparam int PIX_W = 8;

    typedef struct packed {
        logic             eof;
        logic             eol;
        logic [PIX_W-1:0] pix;
    } entry_t;

    localparam int ENTRY_W = PIX_W + 2;

    localparam int DEF_IMG_WIDTH  = 32;
    localparam int DEF_IMG_HEIGHT = 32;
    localparam int DEF_DEPTH      = 16;

endpackage

// File: rtl/pixel_sink_mem.sv
// pixel_sink_mem
// DEPTH x ENTRY_W storage for the pixel sink FIFO. One synchronous write
// port, one asynchronous (combinational) read port. Contents are not reset.
// Ports:
//   clk    - clock
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - read data, combinational from raddr
module pixel_sink_mem
    import pixel_sink_pkg::*;
#(
    parameter  int DEPTH = DEF_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic [AW-1:0]      raddr,
    output logic [ENTRY_W-1:0] rdata
);

    logic [ENTRY_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pixel_sink_fifo.sv
// pixel_sink_fifo
// Show-ahead FIFO at the end of a pixel pipeline. Each pushed pixel is tagged
// with end-of-line / end-of-frame flags derived from write-side column and row
// counters, so the tags travel with the data through the FIFO.
// Ports:
//   clk, rstn            - clock, synchronous active-low reset
//   pixel_in, VALID_IN   - upstream pixel and its valid
//   READY_OUT            - block accepts pixel_in this cycle
//   pixel_out, eol, eof  - head entry (zero while empty)
//   VALID_OUT, READY_IN  - head valid / downstream takes head
//   flush                - synchronous clear of FIFO and position counters
//   level                - current occupancy
// Optional (macro PIXEL_SINK_STATS_EN):
//   frame_count          - pops of entries carrying eof, wraps at 16 bits
//   max_level            - high-water mark of level
module pixel_sink_fifo
    import pixel_sink_pkg::*;
#(
    parameter  int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter  int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter  int DEPTH      = DEF_DEPTH,
    localparam int AW         = $clog2(DEPTH),
    localparam int LVL_W      = AW + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [PIX_W-1:0] pixel_in,
    input  logic             VALID_IN,
    output logic             READY_OUT,
    output logic [PIX_W-1:0] pixel_out,
    output logic             VALID_OUT,
    input  logic             READY_IN,
    output logic             eol,
    output logic             eof,
    input  logic             flush,
`ifdef PIXEL_SINK_STATS_EN
    output logic [15:0]      frame_count,
    output logic [LVL_W-1:0] max_level,
`endif
    output logic [LVL_W-1:0] level
);

    localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    logic [LVL_W-1:0] level_q,  level_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [COL_W-1:0] col_q,    col_d;
    logic [ROW_W-1:0] row_q,    row_d;

    logic               push;
    logic               pop;
    entry_t             wr_entry;
    entry_t             rd_entry;
    logic [ENTRY_W-1:0] rd_raw;

    pixel_sink_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .raddr (rd_ptr_q),
        .rdata (rd_raw)
    );

    assign rd_entry = entry_t'(rd_raw);

    // READY_OUT deliberately ignores READY_IN: a full FIFO stays not-ready
    // even when a pop is happening in the same cycle.
    assign READY_OUT = rstn && (level_q != LVL_W'(DEPTH)) && !flush;
    assign VALID_OUT = (level_q != '0);

    // Storage is not reset, so the head fields are masked while empty.
    assign pixel_out = VALID_OUT ? rd_entry.pix : '0;
    assign eol       = VALID_OUT ? rd_entry.eol : 1'b0;
    assign eof       = VALID_OUT ? rd_entry.eof : 1'b0;
    assign level     = level_q;

    always_comb begin
        level_d  = level_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        col_d    = col_q;
        row_d    = row_q;

        push = VALID_IN && READY_OUT;
        pop  = VALID_OUT && READY_IN && !flush;

        wr_entry.pix = pixel_in;
        wr_entry.eol = (col_q == COL_W'(IMG_WIDTH - 1));
        wr_entry.eof = wr_entry.eol && (row_q == ROW_W'(IMG_HEIGHT - 1));

        if (flush) begin
            level_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            col_d    = '0;
            row_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                if (wr_entry.eol) begin
                    col_d = '0;
                    row_d = wr_entry.eof ? '0 : row_q + ROW_W'(1);
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            level_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            col_q    <= '0;
            row_q    <= '0;
        end else begin
            level_q  <= level_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            col_q    <= col_d;
            row_q    <= row_d;
        end
    end

`ifdef PIXEL_SINK_STATS_EN
    logic [15:0]      frame_count_q, frame_count_d;
    logic [LVL_W-1:0] max_level_q,   max_level_d;

    // The high-water mark tracks the next level so it never lags a peak.
    always_comb begin
        frame_count_d = frame_count_q;
        max_level_d   = max_level_q;
        if (flush) begin
            frame_count_d = '0;
            max_level_d   = '0;
        end else begin
            if (pop && rd_entry.eof) begin
                frame_count_d = frame_count_q + 16'd1;
            end
            if (level_d > max_level_q) begin
                max_level_d = level_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            frame_count_q <= '0;
            max_level_q   <= '0;
        end else begin
            frame_count_q <= frame_count_d;
            max_level_q   <= max_level_d;
        end
    end

    assign frame_count = frame_count_q;
    assign max_level   = max_level_q;
`endif

endmodule

// File: tb/tb_pixel_sink_fifo.sv
// tb_pixel_sink_fifo
// Directed bench for pixel_sink_fifo with default geometry (32x32, DEPTH 16).
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 time
// unit after that, well away from the next edge.
module tb_pixel_sink_fifo;

    logic       clk;
    logic       rstn;
    logic [7:0] pixel_in;
    logic       VALID_IN;
    logic       READY_OUT;
    logic [7:0] pixel_out;
    logic       VALID_OUT;
    logic       READY_IN;
    logic       eol;
    logic       eof;
    logic       flush;
    logic [4:0] level;
`ifdef PIXEL_SINK_STATS_EN
    logic [15:0] frame_count;
    logic [4:0]  max_level;
`endif

    int testCount;
    int failCount;
    int eolSeen;
    int eofSeen;

    pixel_sink_fifo dut (
        .clk         (clk),
        .rstn        (rstn),
        .pixel_in    (pixel_in),
        .VALID_IN    (VALID_IN),
        .READY_OUT   (READY_OUT),
        .pixel_out   (pixel_out),
        .VALID_OUT   (VALID_OUT),
        .READY_IN    (READY_IN),
        .eol         (eol),
        .eof         (eof),
        .flush       (flush),
`ifdef PIXEL_SINK_STATS_EN
        .frame_count (frame_count),
        .max_level   (max_level),
`endif
        .level       (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] p,
                                 input logic r, input logic f);
        VALID_IN = v;
        pixel_in = p;
        READY_IN = r;
        flush    = f;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Streams nPix pixels starting from column 0 / row 0 and checks every pop
    // against a scoreboard whose eol/eof tags come from the bench's own
    // position counters.
    task automatic runTraffic(input int nPix, input bit rnd);
        int         pushed = 0;
        int         popped = 0;
        int         cycles = 0;
        int         mCol   = 0;
        int         mRow   = 0;
        logic [9:0] q[$];
        logic [9:0] e;
        logic       v;
        logic       r;
        logic       eEol;
        logic       eEof;
        logic [7:0] p;
        eolSeen = 0;
        eofSeen = 0;
        while (popped < nPix && cycles < 20000) begin
            v = (pushed < nPix) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
            r = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            p = rnd ? 8'($urandom) : 8'(pushed);
            applyStimulus(v, p, r, 1'b0);
            if (VALID_OUT && READY_IN) begin
                popped++;
                if (eol) eolSeen++;
                if (eof) eofSeen++;
                if (q.size() == 0) begin
                    checkOutput("popUnexpected", 32'(VALID_OUT), 32'd0);
                end else begin
                    e = q.pop_front();
                    checkOutput("popPixel", 32'(pixel_out), 32'(e[7:0]));
                    checkOutput("popEol", 32'(eol), 32'(e[8]));
                    checkOutput("popEof", 32'(eof), 32'(e[9]));
                end
            end
            if (VALID_IN && READY_OUT) begin
                eEol = (mCol == 31);
                eEof = eEol && (mRow == 31);
                q.push_back({eEof, eEol, p});
                if (eEol) begin
                    mCol = 0;
                    mRow = (mRow == 31) ? 0 : mRow + 1;
                end else begin
                    mCol++;
                end
                pushed++;
            end
            nextCycle();
            cycles++;
        end
        checkOutput("trafficPopCount", 32'(popped), 32'(nPix));
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        testCount = 0;
        failCount = 0;
        rstn      = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (3) nextCycle();

        // Reset state
        checkOutput("rstLevel", 32'(level), 32'd0);
        checkOutput("rstValidOut", 32'(VALID_OUT), 32'd0);
        checkOutput("rstReadyOut", 32'(READY_OUT), 32'd0);
        checkOutput("rstPixelOut", 32'(pixel_out), 32'd0);
        checkOutput("rstEol", 32'(eol), 32'd0);
        checkOutput("rstEof", 32'(eof), 32'd0);

        // Scenario 1: single push, one-cycle latency
        rstn = 1'b1;
        applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
        checkOutput("s1ReadyOut", 32'(READY_OUT), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("s1ValidOut", 32'(VALID_OUT), 32'd1);
        checkOutput("s1PixelOut", 32'(pixel_out), 32'h5A);
        checkOutput("s1Level", 32'(level), 32'd1);
        checkOutput("s1Eol", 32'(eol), 32'd0);
        nextCycle();
        checkOutput("s1Hold", 32'(pixel_out), 32'h5A);

        // Scenario 2: fill to full, reject 17th, single pop
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("s2FlushReady", 32'(READY_OUT), 32'd0);
        nextCycle();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("s2FlushLevel", 32'(level), 32'd0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
            nextCycle();
        end
        applyStimulus(1'b1, 8'h20, 1'b0, 1'b0);
        checkOutput("s2FullLevel", 32'(level), 32'd16);
        checkOutput("s2FullReady", 32'(READY_OUT), 32'd0);
        nextCycle();
        checkOutput("s2RejectLevel", 32'(level), 32'd16);
        applyStimulus(1'b1, 8'h20, 1'b1, 1'b0);
        checkOutput("s2NoReadyWithPop", 32'(READY_OUT), 32'd0);
        nextCycle();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("s2PopLevel", 32'(level), 32'd15);
        checkOutput("s2PopReady", 32'(READY_OUT), 32'd1);
        checkOutput("s2Head", 32'(pixel_out), 32'h11);

        // Scenario 3: one full frame plus one pixel, streaming
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        nextCycle();
        runTraffic(1025, 1'b0);
        checkOutput("s3EolCount", 32'(eolSeen), 32'd32);
        checkOutput("s3EofCount", 32'(eofSeen), 32'd1);

        // Scenario 4: flush beats simultaneous push and pop
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        nextCycle();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
            nextCycle();
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("s4Level8", 32'(level), 32'd8);
        applyStimulus(1'b1, 8'hAA, 1'b1, 1'b1);
        checkOutput("s4FlushReady", 32'(READY_OUT), 32'd0);
        nextCycle();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("s4Level", 32'(level), 32'd0);
        checkOutput("s4ValidOut", 32'(VALID_OUT), 32'd0);
        runTraffic(32, 1'b0);
        checkOutput("s4EolCount", 32'(eolSeen), 32'd1);

        // Scenario 6: reset mid-row with 5 entries stored
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
            nextCycle();
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("s6Level5", 32'(level), 32'd5);
        rstn = 1'b0;
        applyStimulus(1'b1, 8'h77, 1'b1, 1'b0);
        checkOutput("s6RstReady", 32'(READY_OUT), 32'd0);
        nextCycle();
        rstn = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("s6Level", 32'(level), 32'd0);
        checkOutput("s6ValidOut", 32'(VALID_OUT), 32'd0);
        runTraffic(32, 1'b0);
        checkOutput("s6EolCount", 32'(eolSeen), 32'd1);
        checkOutput("s6EofCount", 32'(eofSeen), 32'd0);

        // Scenario 5: random handshakes over three frames
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        nextCycle();
        runTraffic(3072, 1'b1);
        checkOutput("s5EofCount", 32'(eofSeen), 32'd3);
        checkOutput("s5EolCount", 32'(eolSeen), 32'd96);
        checkOutput("s5Empty", 32'(level), 32'd0);
`ifdef PIXEL_SINK_STATS_EN
        checkOutput("s5FrameCount", 32'(frame_count), 32'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
